// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus used by the fetch stage.
// The master issues a held request; the slave answers with ack and read data.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IMEM_REQ;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic              IMEM_ACK;
    logic [DATA_W-1:0] IMEM_RDATA;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_ACK,
        input  IMEM_RDATA
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_ACK,
        output IMEM_RDATA
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus, fills one output slot.
// Optional IF_ALIGN_CHECK_EN: word-align branch targets and flag misaligned ones.
module if_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 STALL,
    input  logic                 BRANCH_TAKEN,
    input  logic [ADDR_W-1:0]    BRANCH_TARGET,
    if_fetch_unit_if.master      imem,
    output logic [DATA_W-1:0]    INSTR_OUT,
    output logic [ADDR_W-1:0]    COUNTER_OUT,
    output logic                 VALID_OUT,
    output logic                 MISALIGN_OUT
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] tgt;
    logic              free_next;

    assign free_next = !valid_q || !STALL;

`ifdef IF_ALIGN_CHECK_EN
    logic mis_q, mis_d;

    assign tgt = {BRANCH_TARGET[ADDR_W-1:2], 2'b00};

    always_comb begin
        mis_d = mis_q | (BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00));
    end

    always_ff @(posedge CLK) begin
        if (!RESET) mis_q <= 1'b0;
        else        mis_q <= mis_d;
    end

    assign MISALIGN_OUT = mis_q;
`else
    assign tgt          = BRANCH_TARGET;
    assign MISALIGN_OUT = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q && STALL;
        unique case (state_q)
            IDLE: begin
                if (!BRANCH_TAKEN && free_next) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem.IMEM_ACK) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!BRANCH_TAKEN) begin
                        instr_d = imem.IMEM_RDATA;
                        cnt_d   = addr_q + ADDR_W'(4);
                        valid_d = 1'b1;
                        pc_d    = pc_q + ADDR_W'(4);
                    end
                end else if (BRANCH_TAKEN) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Old request must complete on the bus; its data is dropped.
                if (imem.IMEM_ACK) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (BRANCH_TAKEN) begin
            pc_d    = tgt;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            cnt_q   <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign imem.IMEM_REQ  = req_q;
    assign imem.IMEM_ADDR = addr_q;
    assign INSTR_OUT      = instr_q;
    assign COUNTER_OUT    = cnt_q;
    assign VALID_OUT      = valid_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model of the fetch stage.
module tb_if_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack_en;
    logic        chk_en;
    logic [31:0] instr, cnt;
    logic        valid, mis;
    logic [31:0] w_instr, w_cnt;
    logic        w_valid, w_mis;
    int          nchecks;
    int          npass;

`ifdef IF_ALIGN_CHECK_EN
    localparam logic [31:0] ALN_EXP = 32'h100;
    localparam logic        MIS_EXP = 1'b1;
`else
    localparam logic [31:0] ALN_EXP = 32'h102;
    localparam logic        MIS_EXP = 1'b0;
`endif

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] eff_tgt(input logic [31:0] t);
`ifdef IF_ALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) w_bus ();

    assign bus.IMEM_ACK   = bus.IMEM_REQ && ack_en;
    assign bus.IMEM_RDATA = bus.IMEM_ACK ? memf(bus.IMEM_ADDR)
                                         : (32'hDEAD0000 ^ bus.IMEM_ADDR);
    assign w_bus.IMEM_ACK   = w_bus.IMEM_REQ;
    assign w_bus.IMEM_RDATA = 32'h0;

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .STALL        (stall),
        .BRANCH_TAKEN (br),
        .BRANCH_TARGET(tgt),
        .imem         (bus),
        .INSTR_OUT    (instr),
        .COUNTER_OUT  (cnt),
        .VALID_OUT    (valid),
        .MISALIGN_OUT (mis)
    );

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFFFFFC)) dut_w (
        .CLK          (clk),
        .RESET        (rst_n),
        .STALL        (1'b0),
        .BRANCH_TAKEN (1'b0),
        .BRANCH_TARGET(32'h0),
        .imem         (w_bus),
        .INSTR_OUT    (w_instr),
        .COUNTER_OUT  (w_cnt),
        .VALID_OUT    (w_valid),
        .MISALIGN_OUT (w_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Transaction model: one outstanding read; 'want' drops when a redirect
    // makes the in-flight data stale.
    logic        m_busy, m_want, m_valid, m_mis;
    logic [31:0] m_pc, m_addr, m_instr, m_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_want  <= 1'b0;
            m_valid <= 1'b0;
            m_mis   <= 1'b0;
            m_pc    <= 32'h0;
            m_addr  <= 32'h0;
            m_instr <= 32'h0;
            m_cnt   <= 32'h0;
        end else begin
            if (m_busy && ack_en) begin
                m_busy <= 1'b0;
                if (m_want && !br) begin
                    m_instr <= memf(m_addr);
                    m_cnt   <= m_addr + 32'd4;
                    m_pc    <= m_addr + 32'd4;
                end
            end else if (!m_busy && !br && (!m_valid || !stall)) begin
                m_busy <= 1'b1;
                m_want <= 1'b1;
                m_addr <= m_pc;
            end
            if (br) m_valid <= 1'b0;
            else if (m_busy && ack_en && m_want) m_valid <= 1'b1;
            else m_valid <= m_valid && stall;
            if (br) begin
                m_pc   <= eff_tgt(tgt);
                m_want <= 1'b0;
            end
`ifdef IF_ALIGN_CHECK_EN
            m_mis <= m_mis | (br && (tgt[1:0] != 2'b00));
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req", 32'(bus.IMEM_REQ), 32'(m_busy));
            chk("m_addr", bus.IMEM_ADDR, m_addr);
            chk("m_valid", 32'(valid), 32'(m_valid));
            chk("m_instr", instr, m_instr);
            chk("m_cnt", cnt, m_cnt);
            chk("m_mis", 32'(mis), 32'(m_mis));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nchecks = 0;
        npass   = 0;
        rst_n   = 1'b0;
        stall   = 1'b0;
        br      = 1'b0;
        tgt     = 32'h0;
        ack_en  = 1'b1;
        chk_en  = 1'b0;
        repeat (3) tick();
        chk("rst_req", 32'(bus.IMEM_REQ), 32'd0);
        chk("rst_addr", bus.IMEM_ADDR, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_cnt", cnt, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mis", 32'(mis), 32'd0);
        chk("rst_w_addr", w_bus.IMEM_ADDR, 32'hFFFFFFFC);
        chk("rst_w_mis", 32'(w_mis), 32'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        for (int p = 1; p <= 6; p++) begin
            tick();
            chk("zw_valid", 32'(valid), 32'((p % 2) == 0));
            if ((p % 2) == 0) begin
                chk("zw_cnt", cnt, 32'(2 * p));
            end else begin
                chk("zw_addr", bus.IMEM_ADDR, 32'(2 * (p - 1)));
                chk("zw_req", 32'(bus.IMEM_REQ), 32'd1);
            end
            if (p == 2) begin
                chk("wrap_cnt", w_cnt, 32'h0);
                chk("wrap_valid", 32'(w_valid), 32'd1);
                chk("wrap_instr", w_instr, 32'h0);
            end
            if (p == 3) chk("wrap_addr", w_bus.IMEM_ADDR, 32'h0);
        end
        stall = 1'b1;
        repeat (5) begin
            tick();
            chk("stl_valid", 32'(valid), 32'd1);
            chk("stl_cnt", cnt, 32'd12);
            chk("stl_req", 32'(bus.IMEM_REQ), 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("rel_addr", bus.IMEM_ADDR, 32'd12);
        chk("rel_req", 32'(bus.IMEM_REQ), 32'd1);
        tick();
        chk("rel_cnt", cnt, 32'd16);
        tick();
        chk("dr_addr0", bus.IMEM_ADDR, 32'd16);
        br = 1'b1;
        tgt = 32'h100;
        ack_en = 1'b0;
        tick();
        br = 1'b0;
        chk("dr_addr1", bus.IMEM_ADDR, 32'd16);
        chk("dr_req1", 32'(bus.IMEM_REQ), 32'd1);
        tick();
        chk("dr_addr2", bus.IMEM_ADDR, 32'd16);
        ack_en = 1'b1;
        tick();
        chk("dr_req3", 32'(bus.IMEM_REQ), 32'd0);
        chk("dr_valid3", 32'(valid), 32'd0);
        tick();
        chk("dr_new_addr", bus.IMEM_ADDR, 32'h100);
        tick();
        chk("dr_cnt", cnt, 32'h104);
        chk("dr_instr", instr, memf(32'h100));
        stall = 1'b1;
        br = 1'b1;
        tgt = 32'h200;
        tick();
        chk("flush_valid", 32'(valid), 32'd0);
        br = 1'b0;
        stall = 1'b0;
        tick();
        chk("flush_addr", bus.IMEM_ADDR, 32'h200);
        br = 1'b1;
        tgt = 32'h102;
        tick();
        chk("bra_valid", 32'(valid), 32'd0);
        chk("bra_req", 32'(bus.IMEM_REQ), 32'd0);
        br = 1'b0;
        tick();
        chk("aln_addr", bus.IMEM_ADDR, ALN_EXP);
        chk("aln_mis", 32'(mis), 32'(MIS_EXP));
        tick();
        chk("aln_cnt", cnt, ALN_EXP + 32'd4);
        tick();
        chk("mid_req", 32'(bus.IMEM_REQ), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_req", 32'(bus.IMEM_REQ), 32'd0);
        chk("mr_addr", bus.IMEM_ADDR, 32'h0);
        chk("mr_valid", 32'(valid), 32'd0);
        chk("mr_cnt", cnt, 32'h0);
        chk("mr_instr", instr, 32'h0);
        chk("mr_mis", 32'(mis), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            stall  = ($urandom_range(0, 9) < 3);
            br     = ($urandom_range(0, 9) == 0);
            ack_en = $urandom_range(0, 1) == 1;
            rst_n  = ($urandom_range(0, 199) != 0);
            case ($urandom_range(0, 3))
                0: tgt = $urandom;
                1: tgt = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
                default: tgt = $urandom & 32'h00000FFC;
            endcase
        end
        tick();
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end
endmodule
